// File: rtl/board_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : board_ram_arbiter
// Purpose  : Single-port arbiter/sequencer for one 2-bit-per-tile board RAM.
//            The video renderer reads with absolute priority and zero added
//            latency. Game-logic accesses and the board-clear sweep only use
//            RAM cycles in which video is idle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   vid_active/vid_addr       renderer owns the RAM this cycle / its address
//   vid_rdata                 RAM read data passed straight to the renderer
//   gm_req/gm_we/gm_addr/     game request (level, held until gm_ack)
//   gm_wdata
//   gm_ack/gm_rdata           one-cycle completion pulse / held read result
//   clr_req                   one-cycle board-clear request pulse
//   clr_busy/clr_done         clear pending or running / completion pulse
//   ram_addr/ram_we/          RAM port (synchronous read, one-cycle latency)
//   ram_wdata/ram_rdata
// ============================================================================
module board_ram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 2,
  parameter int CLR_DEPTH = 256,
  parameter int CLR_VALUE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_active,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              gm_req,
  input  logic              gm_we,
  input  logic [ADDR_W-1:0] gm_addr,
  input  logic [DATA_W-1:0] gm_wdata,
  output logic              gm_ack,
  output logic [DATA_W-1:0] gm_rdata,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W:0]   CLR_LAST = (ADDR_W+1)'(CLR_DEPTH - 1);
  localparam logic [DATA_W-1:0] CLR_DATA = DATA_W'(CLR_VALUE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_CAPTURE = 3'd2,
    S_ACK     = 3'd3,
    S_CLEAR   = 3'd4
  } state_t;

  state_t            state;
  logic              clr_pend;
  logic [ADDR_W:0]   clr_cnt;

  assign clr_busy  = clr_pend;
  assign vid_rdata = ram_rdata;

  // RAM port mux: video always wins; otherwise the owner implied by state.
  always_comb begin
    ram_addr  = vid_addr;
    ram_we    = 1'b0;
    ram_wdata = gm_wdata;
    if (!vid_active) begin
      if (state == S_ACCESS) begin
        ram_addr  = gm_addr;
        ram_we    = gm_we;
        ram_wdata = gm_wdata;
      end else if (state == S_CLEAR) begin
        ram_addr  = clr_cnt[ADDR_W-1:0];
        ram_we    = 1'b1;
        ram_wdata = CLR_DATA;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      gm_ack   <= 1'b0;
      gm_rdata <= '0;
      clr_pend <= 1'b0;
      clr_done <= 1'b0;
      clr_cnt  <= '0;
    end else begin
      gm_ack   <= 1'b0;
      clr_done <= 1'b0;

      // A request arriving while a clear is already pending/running is
      // dropped so the sweep never restarts.
      if (clr_req && !clr_pend) begin
        clr_pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          // clr_req is looked at directly so that a clear arriving in the
          // same cycle as a game request still goes first.
          if (clr_pend || clr_req) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end else if (gm_req) begin
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // RAM is only really driven in a video-idle cycle; otherwise retry.
          if (!vid_active) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (!gm_we) begin
            gm_rdata <= ram_rdata;
          end
          gm_ack <= 1'b1;
          state  <= S_ACK;
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        S_CLEAR: begin
          if (!vid_active) begin
            if (clr_cnt == CLR_LAST) begin
              clr_cnt  <= '0;
              clr_pend <= 1'b0;
              clr_done <= 1'b1;
              state    <= S_IDLE;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_board_ram_arbiter
// Purpose  : Self-checking bench for board_ram_arbiter. Provides the board
//            RAM (synchronous read) plus a reference copy of its expected
//            contents, and predicts every response from the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  logic vid_active;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic gm_req, gm_we, gm_ack;
  logic [AW-1:0] gm_addr;
  logic [DW-1:0] gm_wdata, gm_rdata;
  logic clr_req, clr_busy, clr_done;
  logic [AW-1:0] ram_addr;
  logic ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  // side port used only to preload the RAM while the arbiter is idle
  logic pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  logic [DW-1:0] bram   [0:(1<<AW)-1];   // the physical RAM
  logic [DW-1:0] shadow [0:(1<<AW)-1];   // expected RAM contents
  logic [DW-1:0] last_rd;                // expected gm_rdata
  int checks = 0;
  int errors = 0;

  board_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLR_DEPTH(DEPTH), .CLR_VALUE(0)) dut (
    .clk(clk), .rst(rst),
    .vid_active(vid_active), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
    .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata),
    .gm_ack(gm_ack), .gm_rdata(gm_rdata),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) bram[ram_addr] <= ram_wdata;
    else if (pl_we) bram[pl_addr] <= pl_data;
    ram_rdata <= bram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, return at the
  // falling edge where outputs are sampled.
  task automatic cyc(input logic va);
    @(posedge clk); #1;
    vid_active = va;
    vid_addr   = AW'($urandom);
    clr_req    = 1'b0;
    @(negedge clk);
  endtask

  task automatic preload(input int lo, input int hi, input bit rnd, input logic [DW-1:0] v);
    for (int a = lo; a <= hi; a++) begin
      @(posedge clk); #1;
      vid_active = 1'b0;
      pl_we = 1'b1; pl_addr = AW'(a); pl_data = rnd ? DW'($urandom) : v;
      shadow[a] = pl_data;
    end
    @(posedge clk); #1;
    pl_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic scan(input string tag);
    int bad = 0;
    for (int a = 0; a < (1 << AW); a++) if (bram[a] !== shadow[a]) bad++;
    chk({tag, " ram_contents_bad"}, bad, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1; gm_req = 1'b0; clr_req = 1'b0;
    vid_active = 1'b0; vid_addr = AW'($urandom);
    #1;
    chk({tag, " gm_ack"}, gm_ack, 0);
    chk({tag, " gm_rdata"}, gm_rdata, 0);
    chk({tag, " clr_busy"}, clr_busy, 0);
    chk({tag, " clr_done"}, clr_done, 0);
    chk({tag, " ram_we"}, ram_we, 0);
    chk({tag, " ram_addr"}, ram_addr, vid_addr);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
  endtask

  // Game transaction, started at the sampling point of an IDLE cycle
  // (cycle 0). The transaction takes the RAM in the first video-idle cycle
  // from cycle 1 on (the slot) and acknowledges two cycles later. Outside the
  // slot the RAM sees the video address; vid_rdata is the RAM content at the
  // previous cycle's address.
  task automatic game_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int hold, input int pct, input string tag);
    int slot = 0, ackc = 0, port_bad = 0, rd_bad = 0;
    logic [AW-1:0] prev_ra, exp_ra;
    logic [DW-1:0] expv;
    gm_we = we; gm_addr = addr; gm_wdata = data; gm_req = 1'b1;
    prev_ra = vid_addr;
    for (int c = 1; c <= 300 && ackc == 0; c++) begin
      cyc((c <= hold) ? 1'b1 : ($urandom_range(99) < pct));
      if (slot == 0 && !vid_active) slot = c;
      exp_ra = (c == slot) ? addr : vid_addr;
      expv = (we && slot != 0 && c - 1 > slot && prev_ra == addr) ? data : shadow[prev_ra];
      if (ram_addr !== exp_ra || ram_we !== (c == slot && we) ||
          (c == slot && we && ram_wdata !== data)) port_bad++;
      if (vid_rdata !== expv) rd_bad++;
      prev_ra = exp_ra;
      if (gm_ack) begin ackc = c; gm_req = 1'b0; end
    end
    gm_req = 1'b0;
    chk({tag, " ack_cycle"}, ackc, slot + 2);
    chk({tag, " ram_port_bad_cycles"}, port_bad, 0);
    chk({tag, " vid_rdata_bad_cycles"}, rd_bad, 0);
    if (!we) last_rd = shadow[addr];
    chk({tag, " gm_rdata"}, gm_rdata, last_rd);
    if (we) shadow[addr] = data;
    cyc(1'b0);
    chk({tag, " ack_single_pulse"}, gm_ack, 0);
  endtask

  // Clear sweep started in an IDLE cycle (cycle 0). Writes happen in the
  // video-idle cycles from cycle 1; clr_done follows the DEPTH-th such cycle.
  task automatic clear_run(input int period, input bit with_gm, input int second_at,
                           input int abort_at, input string tag);
    int writes = 0, idle_cnt = 0, done_exp = 0, done_c = 0, dones = 0;
    int busy_bad = 0, wr_bad = 0, gslot = 0, ack_c = 0, post = 0;
    bit aborted = 0;
    logic va;
    clr_req = 1'b1;
    if (with_gm) begin gm_we = 1'b1; gm_addr = 'h050; gm_wdata = 2'd3; gm_req = 1'b1; end
    for (int c = 1; c <= 1500; c++) begin
      if (abort_at > 0 && writes == abort_at) begin
        do_reset({tag, " reset"});
        aborted = 1;
        break;
      end
      va = (period > 0) ? (((c / period) % 2) == 1) : 1'b0;
      cyc(va);
      if (c == second_at) clr_req = 1'b1;
      if (!va && done_exp == 0) begin
        idle_cnt++;
        if (idle_cnt == DEPTH) done_exp = c + 1;
      end
      if (with_gm && done_exp != 0 && c > done_exp && gslot == 0 && !va) gslot = c;
      if (ram_we && (done_exp == 0 || c < done_exp)) begin
        if (ram_addr !== AW'(writes) || ram_wdata !== 2'd0 || vid_active) wr_bad++;
        writes++;
      end else if (ram_we && !(with_gm && c == gslot)) wr_bad++;
      if (done_exp == 0 || c < done_exp) begin
        if (clr_busy !== 1'b1 || clr_done !== 1'b0) busy_bad++;
      end else if (c == done_exp) begin
        if (clr_busy !== 1'b0) busy_bad++;
      end else if (clr_done !== 1'b0 || clr_busy !== 1'b0) busy_bad++;
      if (clr_done === 1'b1) begin dones++; if (done_c == 0) done_c = c; end
      if (gm_ack === 1'b1) begin gm_req = 1'b0; if (ack_c == 0) ack_c = c; end
      if (done_exp != 0 && c >= done_exp + 1 && (!with_gm || (ack_c != 0 && c >= ack_c + 1))) break;
    end
    if (aborted) begin
      for (int i = 0; i < 300; i++) begin
        cyc(1'b0);
        post += int'(clr_done) + int'(gm_ack) + int'(ram_we);
      end
      chk({tag, " writes_before_reset"}, writes, abort_at);
      chk({tag, " activity_after_reset"}, post, 0);
      for (int a = 0; a < abort_at; a++) shadow[a] = '0;
    end else begin
      chk({tag, " done_cycle"}, done_c, done_exp);
      chk({tag, " done_count"}, dones, 1);
      chk({tag, " clear_writes"}, writes, DEPTH);
      chk({tag, " clear_write_bad"}, wr_bad, 0);
      chk({tag, " busy_bad_cycles"}, busy_bad, 0);
      for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
      if (with_gm) begin
        chk({tag, " gm_ack_cycle"}, ack_c, gslot + 2);
        chk({tag, " gm_rdata_held"}, gm_rdata, last_rd);
        shadow['h050] = 2'd3;
      end
    end
    scan(tag);
  endtask

  initial begin
    rst = 1'b1; vid_active = 1'b0; vid_addr = 'h155;
    gm_req = 1'b0; gm_we = 1'b0; gm_addr = '0; gm_wdata = '0; clr_req = 1'b0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0; last_rd = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst gm_ack", gm_ack, 0);
    chk("rst gm_rdata", gm_rdata, 0);
    chk("rst clr_busy", clr_busy, 0);
    chk("rst clr_done", clr_done, 0);
    chk("rst ram_we", ram_we, 0);
    chk("rst ram_addr", ram_addr, 'h155);
    rst = 1'b0;

    preload(0, (1 << AW) - 1, 1'b1, '0);

    // basic write then read, no video
    game_op(1'b1, 'h023, 2'd3, 0, 0, "wr023");
    game_op(1'b0, 'h023, 2'd0, 0, 0, "rd023");
    chk("rd023 value", gm_rdata, 3);

    // random traffic with random video interference
    for (int i = 0; i < 16; i++)
      game_op(1'($urandom), AW'($urandom), DW'($urandom), 0, 30, "rnd");

    // video priority: write held off by 50 video cycles
    game_op(1'b1, 'h100, 2'd1, 50, 0, "vidprio");

    // clear sweep with video toggling every 8 cycles
    preload(0, 511, 1'b0, 2'd2);
    clear_run(8, 1'b0, 0, 0, "clear");
    chk("clear addr256 kept", bram[256], 2);

    // clear + game request together, plus a second clr_req mid-sweep
    preload(0, 511, 1'b0, 2'd2);
    clear_run(5, 1'b1, 100, 0, "collide");

    // reset during ACCESS
    game_op(1'b1, 'h200, 2'd3, 0, 0, "wr200");
    game_op(1'b0, 'h200, 2'd0, 0, 0, "rd200");
    gm_we = 1'b1; gm_addr = 'h201; gm_wdata = ~shadow['h201]; gm_req = 1'b1;
    repeat (3) cyc(1'b1);
    do_reset("rst_access");
    begin
      int post = 0;
      for (int i = 0; i < 20; i++) begin
        cyc(1'b0);
        post += int'(gm_ack) + int'(ram_we) + int'(clr_done);
      end
      chk("rst_access activity_after", post, 0);
    end
    chk("rst_access ram_kept", bram['h201], shadow['h201]);

    // reset during CLEAR at clr_cnt=100
    game_op(1'b0, 'h200, 2'd0, 0, 0, "rd200b");
    preload(0, 511, 1'b0, 2'd2);
    clear_run(0, 1'b0, 0, 100, "rst_clear");

    // arbiter still works after aborted sweep
    game_op(1'b0, 'h064, 2'd0, 0, 20, "post_rd100");
    chk("post_rd100 value", gm_rdata, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
